// File: rtl/demux4_stream_if.sv
// Handshake bundle for the 1-to-4 stream demux: one producer channel in,
// four consumer channels out, plus the per-channel delivered-word counters.
interface demux4_stream_if #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
);
  logic [WIDTH-1:0]   din;
  logic [1:0]         select;
  logic               in_valid;
  logic               in_ready;

  logic [WIDTH-1:0]   dout1, dout2, dout3, dout4;
  logic               dout1_valid, dout2_valid, dout3_valid, dout4_valid;
  logic               dout1_ready, dout2_ready, dout3_ready, dout4_ready;
  logic [COUNT_W-1:0] cnt1, cnt2, cnt3, cnt4;

  modport slave (
    input  din, select, in_valid,
    input  dout1_ready, dout2_ready, dout3_ready, dout4_ready,
    output in_ready,
    output dout1, dout2, dout3, dout4,
    output dout1_valid, dout2_valid, dout3_valid, dout4_valid,
    output cnt1, cnt2, cnt3, cnt4
  );

  modport master (
    output din, select, in_valid,
    output dout1_ready, dout2_ready, dout3_ready, dout4_ready,
    input  in_ready,
    input  dout1, dout2, dout3, dout4,
    input  dout1_valid, dout2_valid, dout3_valid, dout4_valid,
    input  cnt1, cnt2, cnt3, cnt4
  );
endinterface

// File: rtl/demux4_stream.sv
// Registered 1-to-4 stream demultiplexer with a one-entry output buffer and
// a wrapping delivered-word counter per output channel.
module demux4_stream #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  demux4_stream_if.slave bus
);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e             state_q;
  logic [1:0]         buf_sel_q;
  logic [3:0]         vld_q;
  logic [WIDTH-1:0]   dout_q [4];
  logic [COUNT_W-1:0] cnt_q  [4];
  logic [COUNT_W-1:0] cnt_d  [4];

  logic [3:0] out_ready;
  logic       sel_ready;
  logic       in_ready;
  logic       deliver;
  logic       accept;

  assign out_ready = {bus.dout4_ready, bus.dout3_ready, bus.dout2_ready, bus.dout1_ready};
  // Only the channel holding the word can drain it; other readies are ignored.
  assign sel_ready = out_ready[buf_sel_q];
  assign in_ready  = rst_n && ((state_q == IDLE) || sel_ready);
  assign deliver   = (state_q == HOLD) && sel_ready;
  assign accept    = bus.in_valid && in_ready;

  always_comb begin
    // NOTE: every element gets its default before the conditional update, so no latch is inferred.
    for (int k = 0; k < 4; k++) cnt_d[k] = cnt_q[k];
    if (deliver) cnt_d[buf_sel_q] = cnt_q[buf_sel_q] + COUNT_W'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: output data registers are reset too, so douts read 0 from the first reset edge.
    if (!rst_n) begin
      state_q   <= IDLE;
      buf_sel_q <= '0;
      vld_q     <= '0;
      for (int k = 0; k < 4; k++) begin
        dout_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];

      case (state_q)
        IDLE:    if (accept) state_q <= HOLD;
        HOLD:    if (deliver && !accept) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      // A refill on the draining edge replaces the word with no bubble.
      if (accept) begin
        buf_sel_q <= bus.select;
        vld_q     <= 4'b0001 << bus.select;
        for (int k = 0; k < 4; k++)
          dout_q[k] <= (bus.select == 2'(k)) ? bus.din : '0;
      end else if (deliver) begin
        vld_q <= '0;
        for (int k = 0; k < 4; k++) dout_q[k] <= '0;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.dout1       = dout_q[0];
  assign bus.dout2       = dout_q[1];
  assign bus.dout3       = dout_q[2];
  assign bus.dout4       = dout_q[3];
  assign bus.dout1_valid = vld_q[0];
  assign bus.dout2_valid = vld_q[1];
  assign bus.dout3_valid = vld_q[2];
  assign bus.dout4_valid = vld_q[3];
  assign bus.cnt1        = cnt_q[0];
  assign bus.cnt2        = cnt_q[1];
  assign bus.cnt3        = cnt_q[2];
  assign bus.cnt4        = cnt_q[3];

endmodule

// File: doc/demux4_stream.md
Name: demux4_stream

Overview:
- Registered 1-to-4 stream demultiplexer; the inverse of the team's 4-to-1 mux.
- Accepts one WIDTH-bit word per handshake on a single input channel and routes it to one of four output channels, chosen by the select value sampled with the word.
- One-entry output buffer, valid/ready handshakes on all five channels, and a per-channel delivered-word counter.
- Sits between a single producer and four consumers in the datapath.

Parameters:
WIDTH, 8, data width of din and dout1..dout4
COUNT_W, 8, width of each per-channel transfer counter

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst_n  input  1  reset, synchronous, active-low
din  input  WIDTH  input data word
select  input  2  destination: 00->dout1, 01->dout2, 10->dout3, 11->dout4
in_valid  input  1  producer offers din/select this cycle
in_ready  output  1  block can accept a word this cycle
dout1..dout4  output  WIDTH each  output data, one port per channel
dout1_valid..dout4_valid  output  1 each  channel holds a word
dout1_ready..dout4_ready  input  1 each  consumer accepts the word
cnt1..cnt4  output  COUNT_W each  words delivered per channel

Behaviour:
- Reset:
  - At a rising edge with rst_n=0: buffer emptied (buf_valid=0), buf_data=0, buf_sel=0, cnt1..cnt4=0.
  - All doutK_valid are 0 and all doutK are 0 after reset.
  - in_ready=0 while rst_n=0.
- State: IDLE (buf_valid=0) and HOLD (buf_valid=1); buf_data[WIDTH] and buf_sel[2] are the buffer contents.
- in_ready = rst_n && (!buf_valid || selected consumer's ready), where the selected consumer is dout(buf_sel+1)_ready. This is combinational and permits a same-cycle drain and refill.
- Accept: in_valid && in_ready at an edge -> buf_data<=din, buf_sel<=select, buf_valid<=1. Latency is 1 cycle; the word appears on its output the cycle after acceptance.
- Outputs:
  - doutK_valid = buf_valid && (buf_sel==K-1).
  - doutK = buf_data when doutK_valid, else 0.
  - At most one doutK_valid is high at any time.
- Deliver: doutK_valid && doutK_ready at an edge -> cntK <= cntK+1, wrapping modulo 2^COUNT_W with no saturation.
  - If no accept occurs in the same cycle, buf_valid<=0.
- Simultaneous deliver and accept: the buffer is replaced by the new word with no bubble. Sustained throughput is 1 word/cycle.
- Stall: while doutK_valid=1 and doutK_ready=0, doutK and buf_sel stay stable, in_ready=0, and no counter changes.
- Readies of unselected channels are ignored; they never cause a transfer or a count.
- din and select are sampled only on the accept edge. Values while in_valid=0 are don't-care.
- Transitions:
  - IDLE -> HOLD on accept.
  - HOLD -> IDLE on deliver without accept.
  - HOLD -> HOLD on stall, or on deliver plus accept.
- Reset mid-operation: a buffered, undelivered word is discarded and not counted; all counters clear to 0.
- No X propagation: all outputs are defined from the first edge with rst_n=0.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with in_valid=1, din=8'hff -> in_ready=0, all valids 0, all dout 0, cnt1..cnt4=0; nothing is accepted after release until in_ready=1.
2. Routing: all readies=1; send 8'h03/sel 00, 8'hac/01, 8'h15/10, 8'h10/11 on consecutive cycles -> each word appears one cycle later, only on dout1, dout2, dout3, dout4 respectively; the other douts read 0; cnt1..cnt4=1.
3. Back-pressure: dout2_ready=0; send 8'hac/sel 01, then offer 8'h15/sel 10 -> dout2_valid=1 holding 8'hac, in_ready=0, 8'h15 not accepted. Raise dout2_ready -> cnt2 increments and 8'h15 is accepted on the same edge, then appears on dout3. Toggling dout1_ready during the stall has no effect.
4. Throughput: 16 back-to-back words, select cycling 00..11, all readies=1 -> 16 deliveries in 17 cycles, in_ready never drops, cnt1..cnt4=4.
5. Counter wrap: 256 words to sel 11, readies=1 -> cnt4 reaches 8'hff, then 8'h00; cnt1..cnt3 stay 0.
6. Reset mid-operation: 8'h5a/sel 00 buffered with dout1_ready=0; pull rst_n low for one edge -> dout1_valid=0, dout1=0, cnt1=0. After release, 8'h5a is not presented again.
